wb_hdmi_pattern_gen: RTL and testbench
======================================

WB_HDMI_PATTERN_GEN -- requirements
Module: wb_hdmi_pattern_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0/0, sync asserted level (0 = active-low).
REQ-006 SHALL have parameter DW, default 8, bits per colour component (DW >= 8).
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 wb_adr_i  in  8  register address; wb_dat_i  in  8  write data; wb_dat_o  out  8  read data.
REQ-010 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone classic cycle/strobe/write; wb_ack_o  out  1  acknowledge.
REQ-011 pix_ce  in  1  pixel-rate clock enable; timing advances only when high.
REQ-012 red, green, blue  out  DW each  pixel components; hsync, vsync, de  out  1 each; frame_start  out  1  one-cycle pulse.

Function
REQ-013 Wishbone: wb_ack_o SHALL assert exactly one cycle after cyc&stb&!ack is sampled, for one cycle; no back-to-back acks.
REQ-014 Registers: 0x10 CTRL (bit0 enable, bits2:1 mode); 0x11/0x12/0x13 solid R/G/B; 0x14 STATUS; 0x15 frame count low byte (RO).
REQ-015 STATUS SHALL read bit0 = in vertical blanking, bit1 = sticky frame_done; writing 1 to bit1 clears it; set wins over simultaneous clear.
REQ-016 Unmapped reads SHALL return 0x00; unmapped and RO writes SHALL be ignored; wb_dat_o valid with ack.
REQ-017 CTRL and solid-colour writes SHALL be shadowed and applied to the pixel path only at frame start (x=0, y=0, pix_ce high).
REQ-018 Counters x in [0, H_TOTAL-1], y in [0, V_TOTAL-1], H_TOTAL = sum of H params, V_TOTAL likewise; x wraps to 0 at H_TOTAL-1, y increments on x wrap and wraps at V_TOTAL-1.
REQ-019 Counters SHALL hold when pix_ce low; all outputs hold.
REQ-020 Raw de = (x < H_ACTIVE) & (y < V_ACTIVE); raw hsync asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vsync likewise on y.
REQ-021 Outputs SHALL be registered with latency exactly 1 pix_ce cycle from counter value; hsync, vsync, de, RGB aligned.
REQ-022 Mode 0 colour bars: 8 bars of H_ACTIVE/8 pixels, order white, yellow, cyan, green, magenta, red, blue, black; remainder pixels black; full = all-ones DW.
REQ-023 Mode 1 solid: components = shadowed 8-bit register left-aligned in DW, low bits zero.
REQ-024 Mode 2 gradient: all components = x[7:0] left-aligned in DW, wraps every 256 pixels.
REQ-025 Mode 3 grid: full white where x[4:0]==0 or y[4:0]==0 or x==H_ACTIVE-1 or y==V_ACTIVE-1, else black.
REQ-026 When de low or shadowed enable low, RGB SHALL be zero; timing continues unaffected.
REQ-027 frame_start SHALL pulse for one cycle with the output of pixel (0,0); frame count increments (mod 256) and frame_done sets at the same cycle.

Reset
REQ-028 rst SHALL clear x, y, frame count, frame_done, wb_ack_o, wb_dat_o, RGB, de, frame_start; hsync/vsync to deasserted level.
REQ-029 rst SHALL set CTRL = 0x01 (enabled, mode 0), solid registers 0x00, and load shadows with these values.
REQ-030 rst mid-frame or mid-transaction SHALL abort with no ack; next frame starts at (0,0).

Verification
REQ-031 Reset, pix_ce=1 -> first de high one cycle after release, hsync low for 96 cycles starting x=656, line period 800, frame 525 lines.
REQ-032 Mode 0 -> pixel 79 white, pixel 80 yellow (R=G=FF, B=00), pixel 560 black at 8-bit DW.
REQ-033 Write 0x11=0x40, 0x10=0x03 mid-frame -> output unchanged until frame_start, then RGB=(40,00,00) all active pixels.
REQ-034 Read 0x14 during vblank after a frame -> 0x03; write 0x02 -> subsequent read 0x01.
REQ-035 pix_ce toggled 1:3 duty -> x/y advance only on enabled cycles, line length 800 enabled cycles.
REQ-036 Read 0x20 -> ack one cycle later, data 0x00; cyc held high -> ack never two consecutive cycles.

Source files
------------

// File: rtl/wb_hdmi_pattern_gen.sv
// Wishbone-controlled video timing generator with colour bar, solid, gradient
// and grid test patterns. Timing advances on pix_ce; register writes reach the
// pixel path only at the start of a frame.
module wb_hdmi_pattern_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0,
    parameter int unsigned DW       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    wb_adr_i,
    input  logic [7:0]    wb_dat_i,
    output logic [7:0]    wb_dat_o,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    output logic          wb_ack_o,
    input  logic          pix_ce,
    output logic [DW-1:0] red,
    output logic [DW-1:0] green,
    output logic [DW-1:0] blue,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic          frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned XW       = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int unsigned YW       = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned BAR_W    = H_ACTIVE / 8;
    localparam int unsigned LSH      = DW - 8;

    localparam logic [7:0] ADR_CTRL   = 8'h10;
    localparam logic [7:0] ADR_RED    = 8'h11;
    localparam logic [7:0] ADR_GREEN  = 8'h12;
    localparam logic [7:0] ADR_BLUE   = 8'h13;
    localparam logic [7:0] ADR_STATUS = 8'h14;
    localparam logic [7:0] ADR_FCNT   = 8'h15;

    // Timing counters
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Host-visible registers and their frame-start shadows
    logic [2:0] ctrl_q, ctrl_d, sh_ctrl_q, sh_ctrl_d;
    logic [7:0] sol_r_q, sol_r_d, sh_r_q, sh_r_d;
    logic [7:0] sol_g_q, sol_g_d, sh_g_q, sh_g_d;
    logic [7:0] sol_b_q, sol_b_d, sh_b_q, sh_b_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic       frame_done_q, frame_done_d;

    // Bus response
    logic       ack_q, ack_d;
    logic [7:0] dat_q, dat_d;

    // Registered video outputs
    logic [DW-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic          hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d;
    logic          frame_start_q, frame_start_d;

    // Combinational helpers
    logic          fs_c, de_raw_c, hs_raw_c, vs_raw_c, vblank_c, grid_c;
    logic [2:0]    eff_ctrl_c;
    logic [7:0]    eff_r_c, eff_g_c, eff_b_c;
    logic [2:0]    bar_c;
    logic [DW-1:0] pix_r_c, pix_g_c, pix_b_c;
    logic          wb_req_c, status_clr_c;

    // Pixel counters advance on pix_ce and wrap at the frame totals
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (pix_ce) begin
            if (32'(x_q) == H_TOTAL - 1) begin
                x_d = '0;
                if (32'(y_q) == V_TOTAL - 1) y_d = '0;
                else                         y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Raw timing decode and the settings that apply to the current pixel
    always_comb begin
        fs_c       = pix_ce && (x_q == '0) && (y_q == '0);
        de_raw_c   = (32'(x_q) < H_ACTIVE) && (32'(y_q) < V_ACTIVE);
        hs_raw_c   = (32'(x_q) >= HS_START) && (32'(x_q) < HS_END);
        vs_raw_c   = (32'(y_q) >= VS_START) && (32'(y_q) < VS_END);
        vblank_c   = 32'(y_q) >= V_ACTIVE;
        eff_ctrl_c = fs_c ? ctrl_q  : sh_ctrl_q;
        eff_r_c    = fs_c ? sol_r_q : sh_r_q;
        eff_g_c    = fs_c ? sol_g_q : sh_g_q;
        eff_b_c    = fs_c ? sol_b_q : sh_b_q;
        sh_ctrl_d  = fs_c ? ctrl_q  : sh_ctrl_q;
        sh_r_d     = fs_c ? sol_r_q : sh_r_q;
        sh_g_d     = fs_c ? sol_g_q : sh_g_q;
        sh_b_d     = fs_c ? sol_b_q : sh_b_q;
    end

    // Pattern generation for the current counter position
    always_comb begin
        pix_r_c = '0;
        pix_g_c = '0;
        pix_b_c = '0;
        bar_c   = 3'd0;
        grid_c  = 1'b0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (32'(x_q) >= i * BAR_W) bar_c = 3'(i);
        end
        if (32'(x_q) >= 8 * BAR_W) bar_c = 3'd7;
        grid_c = (5'(x_q) == 5'd0) || (5'(y_q) == 5'd0) ||
                 (32'(x_q) == H_ACTIVE - 1) || (32'(y_q) == V_ACTIVE - 1);
        case (eff_ctrl_c[2:1])
            2'd0: begin
                pix_r_c = bar_c[1] ? '0 : '1;
                pix_g_c = bar_c[2] ? '0 : '1;
                pix_b_c = bar_c[0] ? '0 : '1;
            end
            2'd1: begin
                pix_r_c = DW'(eff_r_c) << LSH;
                pix_g_c = DW'(eff_g_c) << LSH;
                pix_b_c = DW'(eff_b_c) << LSH;
            end
            2'd2: begin
                pix_r_c = DW'(8'(x_q)) << LSH;
                pix_g_c = DW'(8'(x_q)) << LSH;
                pix_b_c = DW'(8'(x_q)) << LSH;
            end
            default: begin
                pix_r_c = grid_c ? '1 : '0;
                pix_g_c = grid_c ? '1 : '0;
                pix_b_c = grid_c ? '1 : '0;
            end
        endcase
        if (!de_raw_c || !eff_ctrl_c[0]) begin
            pix_r_c = '0;
            pix_g_c = '0;
            pix_b_c = '0;
        end
    end

    // Output stage: one pix_ce of latency, held while pix_ce is low
    always_comb begin
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        frame_start_d = fs_c;
        if (pix_ce) begin
            red_d   = pix_r_c;
            green_d = pix_g_c;
            blue_d  = pix_b_c;
            hsync_d = hs_raw_c ? HS_POL : ~HS_POL;
            vsync_d = vs_raw_c ? VS_POL : ~VS_POL;
            de_d    = de_raw_c;
        end
    end

    // Wishbone slave: single-cycle registered ack, register file and status
    always_comb begin
        wb_req_c     = wb_cyc_i && wb_stb_i && !ack_q;
        ack_d        = wb_req_c;
        dat_d        = 8'h00;
        ctrl_d       = ctrl_q;
        sol_r_d      = sol_r_q;
        sol_g_d      = sol_g_q;
        sol_b_d      = sol_b_q;
        status_clr_c = 1'b0;
        if (wb_req_c && wb_we_i) begin
            case (wb_adr_i)
                ADR_CTRL:   ctrl_d       = wb_dat_i[2:0];
                ADR_RED:    sol_r_d      = wb_dat_i;
                ADR_GREEN:  sol_g_d      = wb_dat_i;
                ADR_BLUE:   sol_b_d      = wb_dat_i;
                ADR_STATUS: status_clr_c = wb_dat_i[1];
                default:    ;
            endcase
        end
        if (wb_req_c && !wb_we_i) begin
            case (wb_adr_i)
                ADR_CTRL:   dat_d = {5'd0, ctrl_q};
                ADR_RED:    dat_d = sol_r_q;
                ADR_GREEN:  dat_d = sol_g_q;
                ADR_BLUE:   dat_d = sol_b_q;
                ADR_STATUS: dat_d = {6'd0, frame_done_q, vblank_c};
                ADR_FCNT:   dat_d = frame_cnt_q;
                default:    dat_d = 8'h00;
            endcase
        end
        frame_cnt_d  = frame_cnt_q + 8'(fs_c);
        frame_done_d = fs_c ? 1'b1 : (status_clr_c ? 1'b0 : frame_done_q);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q           <= '0;
            y_q           <= '0;
            ctrl_q        <= 3'b001;
            sh_ctrl_q     <= 3'b001;
            sol_r_q       <= 8'h00;
            sol_g_q       <= 8'h00;
            sol_b_q       <= 8'h00;
            sh_r_q        <= 8'h00;
            sh_g_q        <= 8'h00;
            sh_b_q        <= 8'h00;
            frame_cnt_q   <= 8'h00;
            frame_done_q  <= 1'b0;
            ack_q         <= 1'b0;
            dat_q         <= 8'h00;
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            ctrl_q        <= ctrl_d;
            sh_ctrl_q     <= sh_ctrl_d;
            sol_r_q       <= sol_r_d;
            sol_g_q       <= sol_g_d;
            sol_b_q       <= sol_b_d;
            sh_r_q        <= sh_r_d;
            sh_g_q        <= sh_g_d;
            sh_b_q        <= sh_b_d;
            frame_cnt_q   <= frame_cnt_d;
            frame_done_q  <= frame_done_d;
            ack_q         <= ack_d;
            dat_q         <= dat_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_wb_hdmi_pattern_gen.sv
// Directed bench for wb_hdmi_pattern_gen: 640x4 active with 800-pixel lines
// and a 10-line frame, so a full frame is 8000 pixel clocks.
module tb_wb_hdmi_pattern_gen;

    localparam int unsigned DW    = 8;
    localparam int unsigned LINE  = 800;
    localparam int unsigned FRAME = 8000;
    localparam int unsigned NONE  = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    wb_adr_i, wb_dat_i, wb_dat_o;
    logic          wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
    logic          pix_ce;
    logic [DW-1:0] red, green, blue;
    logic          hsync, vsync, de, frame_start;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    int unsigned cnt   = 0;

    wb_hdmi_pattern_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b0), .VS_POL(1'b0), .DW(DW)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_ack_o(wb_ack_o), .pix_ce(pix_ce),
        .red(red), .green(green), .blue(blue),
        .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Number of enabled edges since reset; outputs show pixel sequence cnt-1
    always @(posedge clk) begin
        if (rst)         cnt <= 0;
        else if (pix_ce) cnt <= cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [7:0] d);
        wb_adr_i = a; wb_dat_i = d; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge clk);
        chk("wr_ack", 32'(wb_ack_o), 1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [7:0] a, output logic [7:0] d);
        wb_adr_i = a; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(negedge clk);
        chk("rd_ack", 32'(wb_ack_o), 1);
        d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_pix(input int unsigned s);
        int unsigned n = 0;
        while (cnt != s + 1 && n < 50000) begin
            @(negedge clk);
            n++;
        end
        chk("wait_pix", cnt, s + 1);
    endtask

    initial begin
        logic [7:0]  rd;
        int unsigned s, guard;
        int unsigned fs_n, hs_n, vs_n, de_n, hs_first, hs_second, vs_first;
        int unsigned acks, dbl, t1, t2, c1, c2, held_bad;
        logic        hs_prev, ack_prev;
        logic [26:0] prev_out;

        rst = 1'b1; pix_ce = 1'b1;
        wb_adr_i = 8'h00; wb_dat_i = 8'h00; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_de", 32'(de), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_rgb", 32'({red, green, blue}), 0);
        chk("rst_fs", 32'(frame_start), 0);
        chk("rst_ack", 32'(wb_ack_o), 0);
        rst = 1'b0;

        // First frame: sync widths, positions, de count and colour bars
        fs_n = 0; hs_n = 0; vs_n = 0; de_n = 0; guard = 0;
        hs_first = NONE; hs_second = NONE; vs_first = NONE; hs_prev = 1'b1;
        do begin
            @(negedge clk);
            s = cnt - 1;
            if (frame_start) begin
                fs_n++;
                if (fs_n == 2) chk("frame_period", s, FRAME);
            end
            if (s == 0) begin
                chk("first_de", 32'(de), 1);
                chk("first_fs", 32'(frame_start), 1);
                chk("px0_white", 32'({red, green, blue}), 32'hFFFFFF);
            end
            if (s < FRAME) begin
                if (!hsync) hs_n++;
                if (!vsync) vs_n++;
                if (de) de_n++;
                if (!hsync && hs_prev) begin
                    if (hs_first == NONE)       hs_first = s;
                    else if (hs_second == NONE) hs_second = s;
                end
                if (!vsync && vs_first == NONE) vs_first = s;
            end
            hs_prev = hsync;
            case (s)
                79:  chk("px79_white", 32'({red, green, blue}), 32'hFFFFFF);
                80:  chk("px80_yellow", 32'({red, green, blue}), 32'hFFFF00);
                560: chk("px560_black", 32'({red, green, blue}), 32'h000000);
                640: chk("px640_de", 32'(de), 0);
                default: ;
            endcase
            guard++;
        end while (s < FRAME && guard < 9000);
        chk("fs_count", fs_n, 2);
        chk("hs_first", hs_first, 656);
        chk("line_period", hs_second - hs_first, LINE);
        chk("hs_low_cnt", hs_n, 960);
        chk("vs_first", vs_first, 4800);
        chk("vs_low_cnt", vs_n, 1600);
        chk("de_cnt", de_n, 2560);

        // Shadowed writes mid-frame take effect only at the next frame start
        wb_write(8'h11, 8'h40);
        wb_write(8'h10, 8'h03);
        wait_pix(FRAME + 100);
        chk("shadow_hold", 32'({red, green, blue}), 32'hFFFF00);
        wait_pix(2 * FRAME);
        chk("fs2", 32'(frame_start), 1);
        chk("solid_px0", 32'({red, green, blue}), 32'h400000);
        wait_pix(2 * FRAME + 639);
        chk("solid_px639", 32'({red, green, blue}), 32'h400000);
        wait_pix(2 * FRAME + 640);
        chk("solid_blank", 32'({red, green, blue}), 0);
        wait_pix(2 * FRAME + 3 * LINE + 5);
        chk("solid_line3", 32'({red, green, blue}), 32'h400000);
        wb_read(8'h10, rd); chk("rd_ctrl", 32'(rd), 8'h03);
        wb_read(8'h11, rd); chk("rd_red", 32'(rd), 8'h40);
        wb_read(8'h12, rd); chk("rd_green", 32'(rd), 8'h00);

        // Status in vertical blanking, sticky clear, frame count, unmapped
        wait_pix(2 * FRAME + 4 * LINE + 10);
        wb_read(8'h14, rd);  chk("status_vbl", 32'(rd), 8'h03);
        wb_write(8'h14, 8'h02);
        wb_read(8'h14, rd);  chk("status_clr", 32'(rd), 8'h01);
        wb_read(8'h15, rd);  chk("fcnt", 32'(rd), 8'h03);
        wb_write(8'h15, 8'hAA);
        wb_read(8'h15, rd);  chk("fcnt_ro", 32'(rd), 8'h03);
        wb_write(8'h20, 8'h55);
        wb_read(8'h20, rd);  chk("unmapped", 32'(rd), 8'h00);

        // Gradient mode
        wb_write(8'h10, 8'h05);
        wait_pix(3 * FRAME + 255);
        chk("grad_255", 32'({red, green, blue}), 32'hFFFFFF);
        wait_pix(3 * FRAME + 300);
        chk("grad_300", 32'({red, green, blue}), 32'h2C2C2C);

        // Grid mode
        wb_write(8'h10, 8'h07);
        wait_pix(4 * FRAME + LINE + 33);
        chk("grid_off", 32'({red, green, blue}), 0);
        wait_pix(4 * FRAME + LINE + 64);
        chk("grid_x64", 32'({red, green, blue}), 32'hFFFFFF);
        wait_pix(4 * FRAME + LINE + 639);
        chk("grid_xlast", 32'({red, green, blue}), 32'hFFFFFF);
        wait_pix(4 * FRAME + 3 * LINE + 33);
        chk("grid_ylast", 32'({red, green, blue}), 32'hFFFFFF);

        // Disabled: black picture, timing unchanged
        wb_write(8'h10, 8'h00);
        wait_pix(5 * FRAME + 100);
        chk("dis_rgb", 32'({red, green, blue}), 0);
        chk("dis_de", 32'(de), 1);
        wait_pix(5 * FRAME + 656);
        chk("dis_hsync", 32'(hsync), 0);

        // Held request: ack must alternate, never two in a row
        wb_adr_i = 8'h20; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        acks = 0; dbl = 0; ack_prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (wb_ack_o && ack_prev) dbl++;
            if (wb_ack_o) acks++;
            ack_prev = wb_ack_o;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        chk("hold_dbl", dbl, 0);
        chk("hold_acks", acks, 3);

        // pix_ce high one clock in four: line = 800 enabled = 3200 clocks
        t1 = NONE; t2 = NONE; c1 = 0; c2 = 0; held_bad = 0;
        hs_prev = hsync;
        prev_out = {hsync, vsync, de, red, green, blue};
        for (int k = 0; k < 10000 && t2 == NONE; k++) begin
            pix_ce = (k % 4 == 0);
            @(negedge clk);
            if (!pix_ce && {hsync, vsync, de, red, green, blue} != prev_out) held_bad++;
            if (hs_prev && !hsync) begin
                if (t1 == NONE) begin
                    t1 = k; c1 = cnt;
                    chk("ce_hs_pos", (cnt - 1) % LINE, 656);
                end else begin
                    t2 = k; c2 = cnt;
                end
            end
            hs_prev = hsync;
            prev_out = {hsync, vsync, de, red, green, blue};
        end
        pix_ce = 1'b1;
        chk("ce_line_clks", t2 - t1, 3200);
        chk("ce_line_en", c2 - c1, LINE);
        chk("ce_hold", held_bad, 0);

        // Reset mid-frame with a transaction pending
        repeat (37) @(negedge clk);
        wb_adr_i = 8'h15; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_ack", 32'(wb_ack_o), 0);
        chk("rst2_de", 32'(de), 0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_fs", 32'(frame_start), 1);
        chk("rst2_px0", 32'({red, green, blue}), 32'hFFFFFF);
        @(negedge clk);
        wb_read(8'h10, rd); chk("rst2_ctrl", 32'(rd), 8'h01);
        wb_read(8'h11, rd); chk("rst2_red", 32'(rd), 8'h00);
        wb_read(8'h15, rd); chk("rst2_fcnt", 32'(rd), 8'h01);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
